// File: rtl/led_rotation_checker_pkg.sv
// Shared definitions for the LED rotation checker: fault codes, FSM states,
// the common start pattern and small helpers used by the checker and its window counter.
package led_rotation_checker_pkg;

  // Also the reset pattern of the companion LED shifter; both sides must agree.
  localparam logic [7:0] DEFAULT_INIT_PATTERN = 8'h1F;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PATTERN = 2'd1,
    ERR_EARLY   = 2'd2,
    ERR_STALL   = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_TRACK     = 2'd1,
    ST_FAULT     = 2'd2
  } state_e;

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // Interval counter width: 16 bits, widened only when the window limit needs more.
  function automatic int gap_width(input longint limit);
    int w;
    w = 16;
    while ((longint'(1) << w) <= limit) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_rotation_checker_interval_window.sv
// Saturating count of clock edges since the last accepted LED value, compared
// against the legal step window [PERIOD-TOL, PERIOD+TOL].
module interval_window
  import led_rotation_checker_pkg::*;
#(
  parameter int unsigned PERIOD = 2,
  parameter int unsigned TOL    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic advance_i,
  output logic at_limit_o,
  output logic too_early_o
);

  localparam int W = gap_width(longint'(PERIOD) + longint'(TOL));
  localparam logic [W-1:0] LIMIT_HI = W'(PERIOD + TOL);
  localparam logic [W-1:0] LIMIT_LO = W'(PERIOD - TOL);

  logic [W-1:0] gap_q;
  logic [W-1:0] gap_d;

  always_comb begin
    gap_d = gap_q;
    if (restart_i) begin
      gap_d = W'(1);
    end else if (advance_i && (gap_q != '1)) begin
      gap_d = gap_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign at_limit_o  = (gap_q == LIMIT_HI);
  assign too_early_o = (gap_q < LIMIT_LO);

endmodule

// File: rtl/led_rotation_checker.sv
// On-chip monitor for a rotating 8-bit LED bus: locks on the start pattern, then
// checks each change is a 1-bit rotate-left arriving inside the quarter-second window.
module led_rotation_checker
  import led_rotation_checker_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter logic [7:0]  INIT_PATTERN = DEFAULT_INIT_PATTERN,
  parameter int unsigned TOL          = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  leds_in,
  input  logic        clr,
  output logic        locked,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int unsigned PERIOD = CLK_FREQ / 4;

  state_e      state_q, state_d;
  logic [7:0]  prev_q, prev_d;
  logic [15:0] count_q, count_d;
  logic        pulse_q, pulse_d;
  err_code_e   err_q, err_d;

  logic gap_restart;
  logic gap_advance;
  logic gap_at_limit;
  logic gap_too_early;

  interval_window #(
    .PERIOD (PERIOD),
    .TOL    (TOL)
  ) u_interval_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (gap_restart),
    .advance_i   (gap_advance),
    .at_limit_o  (gap_at_limit),
    .too_early_o (gap_too_early)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    count_d     = count_q;
    pulse_d     = 1'b0;
    err_d       = err_q;
    gap_restart = 1'b0;
    gap_advance = 1'b0;

    if (clr) begin
      state_d = ST_WAIT_INIT;
      count_d = '0;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        ST_WAIT_INIT: begin
          if (leds_in == INIT_PATTERN) begin
            prev_d      = leds_in;
            gap_restart = 1'b1;
            count_d     = '0;
            state_d     = ST_TRACK;
          end
        end

        ST_TRACK: begin
          if (leds_in == prev_q) begin
            if (gap_at_limit) begin
              state_d = ST_FAULT;
              err_d   = ERR_STALL;
            end else begin
              gap_advance = 1'b1;
            end
          end else if (leds_in != rotl1(prev_q)) begin
            // A wrong pattern outranks bad timing: the value itself is untrustworthy.
            state_d = ST_FAULT;
            err_d   = ERR_PATTERN;
          end else if (gap_too_early) begin
            state_d = ST_FAULT;
            err_d   = ERR_EARLY;
          end else begin
            prev_d      = leds_in;
            gap_restart = 1'b1;
            count_d     = count_q + 16'd1;
            pulse_d     = 1'b1;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_WAIT_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_INIT;
      prev_q  <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign locked     = (state_q == ST_TRACK);
  assign error      = (state_q == ST_FAULT);
  assign step_pulse = pulse_q;
  assign step_count = count_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_led_rotation_checker.sv
// Randomized and directed bench for led_rotation_checker; two instances (TOL=0 and TOL=1)
// are compared every cycle against an edge-index reference model.
module tb_led_rotation_checker;

  localparam int         N_DUT = 2;
  localparam logic [7:0] INIT  = 8'h1F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  leds_in;
  logic        clr;

  logic        locked_w   [N_DUT];
  logic        pulse_w    [N_DUT];
  logic [15:0] count_w    [N_DUT];
  logic        error_w    [N_DUT];
  logic [1:0]  err_code_w [N_DUT];

  always #5 clk = ~clk;

  led_rotation_checker #(.CLK_FREQ(8), .INIT_PATTERN(INIT), .TOL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .clr(clr),
    .locked(locked_w[0]), .step_pulse(pulse_w[0]), .step_count(count_w[0]),
    .error(error_w[0]), .err_code(err_code_w[0])
  );

  led_rotation_checker #(.CLK_FREQ(8), .INIT_PATTERN(INIT), .TOL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .clr(clr),
    .locked(locked_w[1]), .step_pulse(pulse_w[1]), .step_count(count_w[1]),
    .error(error_w[1]), .err_code(err_code_w[1])
  );

  // Reference model: timing is measured as the difference of edge indices.
  int          m_period [N_DUT] = '{2, 2};
  int          m_tol    [N_DUT] = '{0, 1};
  bit          m_locked [N_DUT];
  bit          m_fault  [N_DUT];
  bit          m_pulse  [N_DUT];
  logic [7:0]  m_prev   [N_DUT];
  int          m_last   [N_DUT];
  logic [15:0] m_count  [N_DUT];
  logic [1:0]  m_err    [N_DUT];
  int          edge_n;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] ref_rotl(input logic [7:0] v);
    logic [7:0] r;
    r = (v << 1) | (v >> 7);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_DUT; i++) begin
      m_locked[i] = 0; m_fault[i] = 0; m_pulse[i] = 0;
      m_prev[i] = '0; m_last[i] = 0; m_count[i] = '0; m_err[i] = 2'd0;
    end
  endtask

  task automatic model_edge(input logic [7:0] s, input bit c);
    edge_n++;
    for (int i = 0; i < N_DUT; i++) begin
      int k;
      k = edge_n - m_last[i];
      m_pulse[i] = 0;
      if (c) begin
        m_locked[i] = 0; m_fault[i] = 0; m_count[i] = '0; m_err[i] = 2'd0;
      end else if (m_fault[i]) begin
        m_locked[i] = 0;
      end else if (!m_locked[i]) begin
        if (s == INIT) begin
          m_locked[i] = 1; m_prev[i] = s; m_last[i] = edge_n; m_count[i] = '0;
        end
      end else if (s == m_prev[i]) begin
        if (k == m_period[i] + m_tol[i]) begin
          m_locked[i] = 0; m_fault[i] = 1; m_err[i] = 2'd3;
        end
      end else if (s != ref_rotl(m_prev[i])) begin
        m_locked[i] = 0; m_fault[i] = 1; m_err[i] = 2'd1;
      end else if (k < m_period[i] - m_tol[i]) begin
        m_locked[i] = 0; m_fault[i] = 1; m_err[i] = 2'd2;
      end else begin
        m_prev[i] = s; m_last[i] = edge_n;
        m_count[i] = m_count[i] + 16'd1; m_pulse[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s d%0d locked", phase, i), 32'(locked_w[i]), 32'(m_locked[i]));
      check($sformatf("%s d%0d step_pulse", phase, i), 32'(pulse_w[i]), 32'(m_pulse[i]));
      check($sformatf("%s d%0d step_count", phase, i), 32'(count_w[i]), 32'(m_count[i]));
      check($sformatf("%s d%0d error", phase, i), 32'(error_w[i]), 32'(m_fault[i]));
      check($sformatf("%s d%0d err_code", phase, i), 32'(err_code_w[i]), 32'(m_err[i]));
    end
  endtask

  // Drive inputs away from the edge, let one edge sample them, then compare 1 time unit later.
  task automatic cycle(input logic [7:0] v, input bit c);
    leds_in = v;
    clr     = c;
    @(posedge clk);
    #1;
    model_edge(v, c);
    check_all("cyc");
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int j = 0; j < n; j++) cycle(v, 1'b0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    logic [7:0] seq [12] = '{8'h3E, 8'h7C, 8'hF8, 8'hF1, 8'hE3, 8'hC7,
                             8'h8F, 8'h1F, 8'h3E, 8'h7C, 8'hF8, 8'hF1};
    int r, h;

    edge_n  = 0;
    rst_n   = 1'b0;
    leds_in = INIT;
    clr     = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    cycle(INIT, 1'b0);
    check("reset_release locked", 32'(locked_w[0]), 32'd1);

    // Good sequence, then a full 8-step wrap.
    cycle(8'h00, 1'b1);
    hold(8'h00, 1);
    hold(INIT, 2);
    for (int s = 0; s < 4; s++) hold(seq[s], 2);
    check("good step_count", 32'(count_w[0]), 32'd4);
    check("good error", 32'(error_w[0]), 32'd0);
    for (int s = 4; s < 12; s++) hold(seq[s], 2);
    check("wrap step_count", 32'(count_w[0]), 32'd12);
    check("wrap locked", 32'(locked_w[0]), 32'd1);
    async_reset();
    check("async locked", 32'(locked_w[0]), 32'd0);

    // Pattern fault.
    hold(INIT, 2);
    hold(8'h3C, 1);
    check("pattern err_code", 32'(err_code_w[0]), 32'd1);
    check("pattern step_count", 32'(count_w[0]), 32'd0);

    // Early fault; the TOL=1 instance accepts the same change.
    cycle(INIT, 1'b1);
    hold(INIT, 1);
    hold(8'h3E, 1);
    check("early err_code", 32'(err_code_w[0]), 32'd2);
    check("early tol1 step_count", 32'(count_w[1]), 32'd1);

    // Stall, then a late change that must not count as a step.
    cycle(INIT, 1'b1);
    hold(INIT, 3);
    check("stall err_code", 32'(err_code_w[0]), 32'd3);
    hold(8'h3E, 1);
    check("stall late err_code", 32'(err_code_w[0]), 32'd3);
    check("stall late step_count", 32'(count_w[0]), 32'd0);

    // Recovery via clr and re-lock.
    cycle(8'h3E, 1'b1);
    check("clr error", 32'(error_w[0]), 32'd0);
    check("clr err_code", 32'(err_code_w[0]), 32'd0);
    hold(INIT, 1);
    check("relock locked", 32'(locked_w[0]), 32'd1);

    // Randomized segments: mostly legal rotations with jittered hold times.
    cur = INIT;
    for (int seg = 0; seg < 700; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cycle(cur, 1'b1);
      end else if (r < 6) begin
        async_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 65)      nxt = ref_rotl(cur);
        else if (r < 80) nxt = INIT;
        else if (r < 92) nxt = 8'($urandom);
        else             nxt = cur;
        r = $urandom_range(0, 9);
        h = (r == 0) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : 4;
        hold(nxt, h);
        cur = nxt;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_rotation_checker.md
# led_rotation_checker

Receive-side companion to the LED shifter: observes an 8-bit LED bus driven by a rotating pattern and checks it on-chip. Each change must be a 1-bit rotate-left of the previous value, and changes must arrive at the expected quarter-second cadence. It reports lock, step count and a sticky fault code. The block sits next to the shifter (or on a looped-back remote LED bus) as a self-check and bring-up monitor.

## Interface
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz. Expected step period is `PERIOD = CLK_FREQ/4` cycles (integer division).
- `INIT_PATTERN`, default 8'h1F: value that starts tracking.
- `TOL`, default 0: allowed deviation of the step interval, in cycles. Requires `PERIOD - TOL >= 1`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `leds_in`, in, 8: observed LED bus; already synchronous to `clk`.
- `clr`, in, 1: synchronous clear of fault and counters.
- `locked`, out, 1: high while in TRACK.
- `step_pulse`, out, 1: one-cycle pulse per accepted rotation.
- `step_count`, out, 16: accepted rotations since lock; wraps mod 2^16.
- `error`, out, 1: sticky fault flag.
- `err_code`, out, 2: 0 = none, 1 = PATTERN, 2 = EARLY, 3 = STALL.

## Operation
- State machine has three states: WAIT_INIT, TRACK, FAULT.
- Internal registers:
  - `prev` (8 bits): last accepted value.
  - `gap` (16 bits, saturating): edges since the last accepted value.
- **WAIT_INIT**:
  - If the sample equals `INIT_PATTERN`: set `prev <= sample`, `gap <= 1`, `step_count <= 0`, go to TRACK.
  - Any other value: remain in WAIT_INIT (not a fault).
- **TRACK**, evaluated on each edge:
  - Sample equals `prev`:
    - If `gap == PERIOD+TOL`: go to FAULT with STALL.
    - Else `gap <= gap+1`.
  - Sample differs from `prev`:
    - If the sample is not `{prev[6:0],prev[7]}`: FAULT with PATTERN.
    - Else if `gap < PERIOD-TOL`: FAULT with EARLY.
    - Else accept: `prev <= sample`, `gap <= 1`, `step_count++`, `step_pulse` = 1.
  - PATTERN takes precedence over EARLY.
  - A change with `gap` in [PERIOD-TOL, PERIOD+TOL] is accepted. Late changes are always caught as STALL first.
- **FAULT**:
  - `error` = 1, `locked` = 0; `err_code` and `step_count` are held.
  - Only `clr` or reset leaves this state.
- **clr** has top priority in every state: go to WAIT_INIT, clear `error`, `err_code`, `step_count`, `step_pulse`.
- **Wrap-around**: 0x80→0x01 style rotation is legal; `step_count` 16'hFFFF→0 is not a fault.

## Timing
- Every output is registered and reflects the sample taken at the preceding rising edge. Latency is one edge.
- Reset values: `locked` = 0, `step_pulse` = 0, `step_count` = 0, `error` = 0, `err_code` = 0, state = WAIT_INIT.
- Asserting `rst_n` low mid-TRACK or mid-FAULT clears all outputs immediately (asynchronous).
- Timing reference: value accepted at edge e0. A change sampled at edge e0+k has interval k.
  - The change is legal iff PERIOD-TOL ≤ k ≤ PERIOD+TOL.
  - With no change, STALL is flagged at edge e0+PERIOD+TOL.
- `locked` rises at the edge that samples `INIT_PATTERN`. It falls at the edge that detects a fault.
- `step_pulse` is high for exactly the cycle after the accepting edge.

## Structure
- Shared package holds:
  - `err_code` encodings: ERR_NONE, ERR_PATTERN, ERR_EARLY, ERR_STALL.
  - State enum.
  - Default `INIT_PATTERN` 8'h1F, shared with the LED shifter.
- Single module. The interval counter (`gap`, with saturation and window compare) is a natural sub-module, `interval_window`.

## Test plan
All scenarios use `CLK_FREQ` = 8 (PERIOD = 2) and `TOL` = 0 unless noted.
1. **Reset:** hold `rst_n` low, drive `leds_in` = 0x1F → all outputs 0. Release reset → `locked` = 1 after the first edge.
2. **Good sequence:** 0x00, then 0x1F, 0x3E, 0x7C, 0xF8, 0xF1, each held 2 cycles → four `step_pulse`s, `step_count` = 4, `error` = 0, `locked` = 1 throughout. Repeat with the LED shifter instance driving `leds_in` directly and run a full 8-step wrap (0xF1…0x1F) → no error.
3. **Pattern fault:** 0x1F then 0x3C after 2 cycles → `error` = 1, `err_code` = 1, `locked` = 0, `step_count` = 0.
4. **Early fault:** 0x1F then 0x3E after 1 cycle → `err_code` = 2. With `TOL` = 1, the same stimulus is accepted and `step_count` = 1.
5. **Stall fault:** 0x1F held → `err_code` = 3 at the second edge after lock. 0x1F held for 3 cycles, then 0x3E → still STALL, no step.
6. **Recovery:** in FAULT, pulse `clr` → WAIT_INIT with `error` = 0, `err_code` = 0, `step_count` = 0. Re-lock on 0x1F. Drop `rst_n` mid-TRACK → outputs cleared asynchronously.
